// File: rtl/ahb_burst_master.sv
// AHB-Lite burst master: pipelined SINGLE/INCR bursts with write-underrun
// BUSY cycles, 1 KB re-NONSEQ and two-cycle ERROR termination.
module ahb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int LW = $clog2(MAX_BURST)
) (
  input  logic                  CLOCK,
  input  logic                  HRESETn,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                  REQ_WRITE,
  input  logic [LW-1:0]         REQ_LEN,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WDATA_VALID,
  output logic                  WDATA_READY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  RDATA_VALID,
  output logic                  DONE,
  output logic                  ERR,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_WIDTH / 8));
  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(DATA_WIDTH / 8);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_LAST, S_ERR1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d, anx_q, anx_d;
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d;
  logic [2:0]            hburst_q, hburst_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d, pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, stg_q, stg_d;
  logic                  rv_q, rv_d, done_q, done_d, err_q, err_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW:0]           nb_q, nb_d;
  logic                  dpv_q, dpv_d, dpw_q, dpw_d;
  logic                  full_q, full_d;
  logic                  take, flush, more, fault, wready;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    anx_d    = anx_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hburst_d = hburst_q;
    hwdata_d = hwdata_q;
    pipe_d   = pipe_q;
    rdata_d  = rdata_q;
    stg_d    = stg_q;
    rv_d     = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    len_d    = len_q;
    nb_d     = nb_q;
    dpv_d    = dpv_q;
    dpw_d    = dpw_q;
    full_d   = full_q;
    take     = 1'b0;
    flush    = 1'b0;
    wready   = 1'b0;
    more     = nb_q <= {1'b0, len_q};
    fault    = dpv_q && HRESP;
    unique case (state_q)
      S_IDLE: begin
        if (REQ_VALID && !done_q) begin
          state_d  = S_ADDR;
          anx_d    = REQ_ADDR;
          len_d    = REQ_LEN;
          nb_d     = '0;
          hwrite_d = REQ_WRITE;
          hburst_d = (REQ_LEN == '0) ? 3'b000 : 3'b001;
        end
      end
      S_ADDR, S_LAST: begin
        if (fault) begin
          htrans_d = T_IDLE;
          dpv_d    = 1'b0;
          if (HREADY) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            flush   = 1'b1;
          end else begin
            state_d = S_ERR1;
          end
        end else if (HREADY) begin
          dpv_d = htrans_q[1];
          dpw_d = hwrite_q;
          if (htrans_q[1] && hwrite_q) hwdata_d = pipe_q;
          if (dpv_q && !dpw_q) begin
            rdata_d = HRDATA;
            rv_d    = 1'b1;
          end
          if (state_q == S_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (!more) begin
            htrans_d = T_IDLE;
            state_d  = S_LAST;
          end else if (hwrite_q && !full_q) begin
            // underrun: park on the next address until data arrives
            htrans_d = (nb_q == '0) ? T_IDLE : T_BUSY;
            if (nb_q != '0) haddr_d = anx_q;
          end else begin
            take     = hwrite_q;
            pipe_d   = stg_q;
            htrans_d = (nb_q == '0 || anx_q[9:0] == '0) ? T_NSEQ : T_SEQ;
            haddr_d  = anx_q;
            anx_d    = anx_q + INC;
            nb_d     = nb_q + (LW+1)'(1);
          end
        end
      end
      S_ERR1: begin
        if (HREADY) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          flush   = 1'b1;
        end
      end
    endcase
    wready = !full_q || take;
    if (take) full_d = 1'b0;
    if (WDATA_VALID && wready) begin
      full_d = 1'b1;
      stg_d  = WDATA;
    end
    if (flush) full_d = 1'b0;
  end

  always_ff @(posedge CLOCK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      anx_q    <= '0;
      htrans_q <= T_IDLE;
      hwrite_q <= 1'b0;
      hburst_q <= '0;
      hwdata_q <= '0;
      pipe_q   <= '0;
      rdata_q  <= '0;
      stg_q    <= '0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      len_q    <= '0;
      nb_q     <= '0;
      dpv_q    <= 1'b0;
      dpw_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      anx_q    <= anx_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hburst_q <= hburst_d;
      hwdata_q <= hwdata_d;
      pipe_q   <= pipe_d;
      rdata_q  <= rdata_d;
      stg_q    <= stg_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
      err_q    <= err_d;
      len_q    <= len_d;
      nb_q     <= nb_d;
      dpv_q    <= dpv_d;
      dpw_q    <= dpw_d;
      full_q   <= full_d;
    end
  end

  assign REQ_READY   = (state_q == S_IDLE) && !done_q;
  assign WDATA_READY = wready;
  assign RDATA       = rdata_q;
  assign RDATA_VALID = rv_q;
  assign DONE        = done_q;
  assign ERR         = err_q;
  assign HADDR       = haddr_q;
  assign HTRANS      = htrans_q;
  assign HWRITE      = hwrite_q;
  assign HSIZE       = SIZE;
  assign HBURST      = hburst_q;
  assign HWDATA      = hwdata_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// Directed bench for ahb_burst_master: checks bus sequencing cycle by cycle
// against hand-derived traces.
module tb_ahb_burst_master;

  logic        CLOCK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        REQ_VALID, REQ_READY, REQ_WRITE;
  logic [31:0] REQ_ADDR;
  logic [3:0]  REQ_LEN;
  logic [31:0] WDATA;
  logic        WDATA_VALID, WDATA_READY;
  logic [31:0] RDATA;
  logic        RDATA_VALID, DONE, ERR;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADY, HRESP;

  int checks = 0;
  int errors = 0;
  logic [31:0] wptr = 32'd0;

  ahb_burst_master dut (
    .CLOCK(CLOCK), .HRESETn(HRESETn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_WRITE(REQ_WRITE), .REQ_LEN(REQ_LEN),
    .WDATA(WDATA), .WDATA_VALID(WDATA_VALID), .WDATA_READY(WDATA_READY),
    .RDATA(RDATA), .RDATA_VALID(RDATA_VALID), .DONE(DONE), .ERR(ERR),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA),
    .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 CLOCK = ~CLOCK;

  // write source: word k carries 0xD000_000k
  assign WDATA = 32'hD000_0000 | wptr;
  always @(posedge CLOCK)
    if (WDATA_VALID && WDATA_READY) wptr <= wptr + 32'd1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge CLOCK);
  endtask

  task automatic go(input logic [31:0] a, input logic w,
                    input logic [3:0] l);
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    REQ_WRITE = w;
    REQ_LEN   = l;
    step;
    REQ_VALID = 1'b0;
  endtask

  task automatic bus(input string tag, input logic [1:0] t,
                     input logic [31:0] a);
    chk({tag, "_htrans"}, 64'(HTRANS), 64'(t));
    chk({tag, "_haddr"}, 64'(HADDR), 64'(a));
  endtask

  int nbeat, nrv, ndone;

  initial begin
    REQ_VALID = 0; REQ_ADDR = 0; REQ_WRITE = 0; REQ_LEN = 0;
    WDATA_VALID = 0; HRDATA = 0; HREADY = 1; HRESP = 0;
    repeat (2) step;
    chk("rst_htrans", 64'(HTRANS), 64'h0);
    chk("rst_haddr", 64'(HADDR), 64'h0);
    chk("rst_hwrite", 64'(HWRITE), 64'h0);
    chk("rst_hburst", 64'(HBURST), 64'h0);
    chk("rst_hwdata", 64'(HWDATA), 64'h0);
    chk("rst_req_ready", 64'(REQ_READY), 64'h1);
    chk("rst_wdata_ready", 64'(WDATA_READY), 64'h1);
    chk("rst_rdata", 64'(RDATA), 64'h0);
    chk("rst_rvalid", 64'(RDATA_VALID), 64'h0);
    chk("rst_done", 64'(DONE), 64'h0);
    chk("rst_err", 64'(ERR), 64'h0);
    chk("hsize", 64'(HSIZE), 64'h2);
    HRESETn = 1'b1;
    step;

    // single read
    go(32'h100, 1'b0, 4'd0);
    chk("t1_pre", 64'(HTRANS), 64'h0);
    step;
    bus("t1_a", 2'b10, 32'h100);
    chk("t1_hburst", 64'(HBURST), 64'h0);
    chk("t1_hwrite", 64'(HWRITE), 64'h0);
    step;
    HRDATA = 32'hCAFE_0001;
    chk("t1_dp", 64'(HTRANS), 64'h0);
    step;
    chk("t1_rvalid", 64'(RDATA_VALID), 64'h1);
    chk("t1_rdata", 64'(RDATA), 64'hCAFE_0001);
    chk("t1_done", 64'(DONE), 64'h1);
    chk("t1_err", 64'(ERR), 64'h0);
    chk("t1_busy_ready", 64'(REQ_READY), 64'h0);
    step;
    chk("t1_done_off", 64'(DONE), 64'h0);
    chk("t1_ready", 64'(REQ_READY), 64'h1);

    // 4-beat write, data always valid
    WDATA_VALID = 1'b1;
    go(32'h200, 1'b1, 4'd3);
    step;
    bus("t2_b0", 2'b10, 32'h200);
    chk("t2_hburst", 64'(HBURST), 64'h1);
    chk("t2_hwrite", 64'(HWRITE), 64'h1);
    step;
    bus("t2_b1", 2'b11, 32'h204);
    chk("t2_wd0", 64'(HWDATA), 64'hD000_0000);
    step;
    bus("t2_b2", 2'b11, 32'h208);
    chk("t2_wd1", 64'(HWDATA), 64'hD000_0001);
    WDATA_VALID = 1'b0;
    step;
    bus("t2_b3", 2'b11, 32'h20C);
    chk("t2_wd2", 64'(HWDATA), 64'hD000_0002);
    step;
    chk("t2_last", 64'(HTRANS), 64'h0);
    chk("t2_wd3", 64'(HWDATA), 64'hD000_0003);
    chk("t2_early_done", 64'(DONE), 64'h0);
    step;
    chk("t2_done", 64'(DONE), 64'h1);
    chk("t2_err", 64'(ERR), 64'h0);
    step;

    // 4-beat read, two wait states on beat 1
    go(32'h200, 1'b0, 4'd3);
    step;
    bus("t3_b0", 2'b10, 32'h200);
    step;
    bus("t3_b1", 2'b11, 32'h204);
    HRDATA = 32'h1111_0000;
    step;
    chk("t3_rv0", 64'(RDATA_VALID), 64'h1);
    chk("t3_rd0", 64'(RDATA), 64'h1111_0000);
    bus("t3_b2", 2'b11, 32'h208);
    HREADY = 1'b0;
    step;
    bus("t3_w1", 2'b11, 32'h208);
    chk("t3_w1_rv", 64'(RDATA_VALID), 64'h0);
    step;
    bus("t3_w2", 2'b11, 32'h208);
    chk("t3_w2_rv", 64'(RDATA_VALID), 64'h0);
    HREADY = 1'b1;
    HRDATA = 32'h1111_0001;
    step;
    chk("t3_rv1", 64'(RDATA_VALID), 64'h1);
    chk("t3_rd1", 64'(RDATA), 64'h1111_0001);
    bus("t3_b3", 2'b11, 32'h20C);
    HRDATA = 32'h1111_0002;
    step;
    chk("t3_rd2", 64'(RDATA), 64'h1111_0002);
    chk("t3_last", 64'(HTRANS), 64'h0);
    chk("t3_nodone", 64'(DONE), 64'h0);
    HRDATA = 32'h1111_0003;
    step;
    chk("t3_rv3", 64'(RDATA_VALID), 64'h1);
    chk("t3_rd3", 64'(RDATA), 64'h1111_0003);
    chk("t3_done", 64'(DONE), 64'h1);
    step;

    // 4-beat write with a two-cycle data underrun after beat 1
    WDATA_VALID = 1'b1;
    go(32'h200, 1'b1, 4'd3);
    step;
    bus("t4_b0", 2'b10, 32'h200);
    WDATA_VALID = 1'b0;
    step;
    bus("t4_b1", 2'b11, 32'h204);
    chk("t4_wd0", 64'(HWDATA), 64'hD000_0004);
    step;
    bus("t4_busy1", 2'b01, 32'h208);
    chk("t4_wd1", 64'(HWDATA), 64'hD000_0005);
    WDATA_VALID = 1'b1;
    step;
    bus("t4_busy2", 2'b01, 32'h208);
    chk("t4_wd1h", 64'(HWDATA), 64'hD000_0005);
    step;
    bus("t4_b2", 2'b11, 32'h208);
    chk("t4_wd1k", 64'(HWDATA), 64'hD000_0005);
    WDATA_VALID = 1'b0;
    step;
    bus("t4_b3", 2'b11, 32'h20C);
    chk("t4_wd2", 64'(HWDATA), 64'hD000_0006);
    step;
    chk("t4_last", 64'(HTRANS), 64'h0);
    chk("t4_wd3", 64'(HWDATA), 64'hD000_0007);
    step;
    chk("t4_done", 64'(DONE), 64'h1);
    chk("t4_err", 64'(ERR), 64'h0);
    step;

    // 1 KB crossing
    go(32'h3F8, 1'b0, 4'd3);
    step;
    bus("t5_b0", 2'b10, 32'h3F8);
    step;
    bus("t5_b1", 2'b11, 32'h3FC);
    step;
    bus("t5_b2", 2'b10, 32'h400);
    chk("t5_hburst", 64'(HBURST), 64'h1);
    step;
    bus("t5_b3", 2'b11, 32'h404);
    step;
    chk("t5_last", 64'(HTRANS), 64'h0);
    step;
    chk("t5_done", 64'(DONE), 64'h1);
    step;

    // ERROR on beat 2 of an 8-beat read
    go(32'h300, 1'b0, 4'd7);
    step;
    bus("t6_b0", 2'b10, 32'h300);
    step;
    HRDATA = 32'hE000_0000;
    step;
    chk("t6_rv0", 64'(RDATA_VALID), 64'h1);
    chk("t6_rd0", 64'(RDATA), 64'hE000_0000);
    HRDATA = 32'hE000_0001;
    step;
    chk("t6_rv1", 64'(RDATA_VALID), 64'h1);
    chk("t6_rd1", 64'(RDATA), 64'hE000_0001);
    bus("t6_b3", 2'b11, 32'h30C);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    step;
    chk("t6_cancel", 64'(HTRANS), 64'h0);
    chk("t6_e1_rv", 64'(RDATA_VALID), 64'h0);
    chk("t6_e1_done", 64'(DONE), 64'h0);
    HREADY = 1'b1;
    step;
    chk("t6_done", 64'(DONE), 64'h1);
    chk("t6_err", 64'(ERR), 64'h1);
    chk("t6_e2_rv", 64'(RDATA_VALID), 64'h0);
    HRESP = 1'b0;
    step;
    chk("t6_ready", 64'(REQ_READY), 64'h1);

    // full-length burst wrapping past the top of the address space
    HRDATA = 32'h5555_AAAA;
    go(32'hFFFF_FFE0, 1'b0, 4'd15);
    nbeat = 0;
    nrv   = 0;
    ndone = 0;
    for (int i = 0; i < 40 && ndone == 0; i++) begin
      step;
      if (HTRANS[1]) begin
        nbeat++;
        if (nbeat == 9) bus("t7_wrap", 2'b10, 32'h0);
      end
      if (RDATA_VALID) nrv++;
      if (DONE) ndone++;
    end
    chk("t7_beats", 64'(nbeat), 64'd16);
    chk("t7_rvalids", 64'(nrv), 64'd16);
    chk("t7_done", 64'(ndone), 64'd1);
    step;

    // asynchronous reset mid-burst
    go(32'h100, 1'b0, 4'd3);
    step;
    bus("t8_b0", 2'b10, 32'h100);
    step;
    #2 HRESETn = 1'b0;
    #1;
    chk("t8_htrans", 64'(HTRANS), 64'h0);
    chk("t8_haddr", 64'(HADDR), 64'h0);
    chk("t8_hburst", 64'(HBURST), 64'h0);
    chk("t8_rdata", 64'(RDATA), 64'h0);
    chk("t8_req_ready", 64'(REQ_READY), 64'h1);
    repeat (3) step;
    chk("t8_nodone", 64'(DONE), 64'h0);
    HRESETn = 1'b1;
    step;
    chk("t8_idle", 64'(HTRANS), 64'h0);
    chk("t8_ready", 64'(REQ_READY), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
